mem_access_unit: RTL and testbench

Memory-side initiator that drives the data memory's Address/writeData/MemRead/MemWrite interface on behalf of the CPU datapath. It accepts one load/store request at a time over a valid/ready handshake. It performs byte, halfword and word accesses on the word-addressed data memory, using read-modify-write for sub-word stores. It returns a one-cycle response carrying aligned, sign- or zero-extended load data, or an error flag.

---
 rtl/mem_access_unit.sv | 182 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store initiator for a word-addressed data memory. Accepts one request
// at a time, performs byte/halfword/word accesses (read-modify-write for
// sub-word stores) and returns a one-cycle response with extended load data
// or an error flag. All outputs are registered.
module mem_access_unit #(
  parameter int unsigned READ_LAT = 1
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrite,
  input  logic [1:0]  ReqSize,
  input  logic        ReqSigned,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqWData,
  output logic        RespValid,
  output logic [31:0] RespData,
  output logic        RespErr,
  output logic [31:0] Address,
  output logic [31:0] writeData,
  output logic        MemRead,
  output logic        MemWrite,
  input  logic [31:0] ReadData
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      state, state_n;

  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        sgn_q, sgn_d;
  logic        wr_q, wr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        ready_d, rvalid_d, rerr_d, mrd_d, mwr_d;
  logic [31:0] rdata_d, maddr_d, mwdata_d;

  logic        accept, req_err, req_needs_read;
  logic [4:0]  shamt;
  logic [31:0] shifted, load_val, lane_mask, merged;

  // Request decode: alignment/size legality and whether a read phase is needed.
  always_comb begin
    accept         = ReqValid && ReqReady && (state == IDLE);
    req_err        = (ReqSize == 2'b11) ||
                     ((ReqSize == 2'b01) && ReqAddr[0]) ||
                     ((ReqSize == 2'b10) && (ReqAddr[1:0] != 2'b00));
    req_needs_read = !ReqWrite || (ReqSize != 2'b10);
  end

  // Little-endian lane extract for loads and lane merge for sub-word stores.
  always_comb begin
    shamt   = {addr_q[1:0], 3'b000};
    shifted = ReadData >> shamt;
    unique case (size_q)
      2'b00:   load_val = sgn_q ? {{24{shifted[7]}}, shifted[7:0]}
                                : {24'h0, shifted[7:0]};
      2'b01:   load_val = sgn_q ? {{16{shifted[15]}}, shifted[15:0]}
                                : {16'h0, shifted[15:0]};
      default: load_val = ReadData;
    endcase
    lane_mask = ((size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << shamt;
    merged    = (ReadData & ~lane_mask) | ((wdata_q << shamt) & lane_mask);
  end

  // Next state plus next value of every registered output; outputs are
  // computed for the state being entered so they line up with it.
  always_comb begin
    state_n  = state;
    addr_d   = addr_q;
    size_d   = size_q;
    sgn_d    = sgn_q;
    wr_d     = wr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    ready_d  = 1'b0;
    rvalid_d = 1'b0;
    rdata_d  = '0;
    rerr_d   = 1'b0;
    maddr_d  = '0;
    mwdata_d = '0;
    mrd_d    = 1'b0;
    mwr_d    = 1'b0;

    unique case (state)
      IDLE: begin
        if (accept) begin
          addr_d  = ReqAddr;
          size_d  = ReqSize;
          sgn_d   = ReqSigned;
          wr_d    = ReqWrite;
          wdata_d = ReqWData;
          if (req_err) begin
            state_n  = RESP;
            rvalid_d = 1'b1;
            rerr_d   = 1'b1;
          end else if (req_needs_read) begin
            state_n = RD;
            cnt_d   = 4'(READ_LAT - 1);
            maddr_d = {ReqAddr[31:2], 2'b00};
            mrd_d   = 1'b1;
          end else begin
            state_n  = WR;
            maddr_d  = {ReqAddr[31:2], 2'b00};
            mwdata_d = ReqWData;
            mwr_d    = 1'b1;
          end
        end else begin
          ready_d = 1'b1;
        end
      end
      RD: begin
        if (cnt_q == 4'd0) begin
          if (!wr_q) begin
            state_n  = RESP;
            rvalid_d = 1'b1;
            rdata_d  = load_val;
          end else begin
            state_n  = WR;
            maddr_d  = {addr_q[31:2], 2'b00};
            mwdata_d = merged;
            mwr_d    = 1'b1;
          end
        end else begin
          cnt_d   = cnt_q - 4'd1;
          maddr_d = {addr_q[31:2], 2'b00};
          mrd_d   = 1'b1;
        end
      end
      WR: begin
        state_n  = RESP;
        rvalid_d = 1'b1;
      end
      RESP: begin
        state_n = IDLE;
        ready_d = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // State, captured request and output registers; reset clears everything.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      sgn_q     <= 1'b0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      ReqReady  <= 1'b0;
      RespValid <= 1'b0;
      RespData  <= '0;
      RespErr   <= 1'b0;
      Address   <= '0;
      writeData <= '0;
      MemRead   <= 1'b0;
      MemWrite  <= 1'b0;
    end else begin
      state     <= state_n;
      addr_q    <= addr_d;
      size_q    <= size_d;
      sgn_q     <= sgn_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      ReqReady  <= ready_d;
      RespValid <= rvalid_d;
      RespData  <= rdata_d;
      RespErr   <= rerr_d;
      Address   <= maddr_d;
      writeData <= mwdata_d;
      MemRead   <= mrd_d;
      MemWrite  <= mwr_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: two instances (READ_LAT=1 and 3),
// each with its own word memory model.
module tb_mem_access_unit;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [1:0]        vld = '0;
  logic              rw = 1'b0;
  logic [1:0]        rsz = '0;
  logic              rsg = 1'b0;
  logic [31:0]       raddr = '0;
  logic [31:0]       rwd = '0;

  logic [1:0]        rdy, rvld, rerr, mrd, mwr;
  logic [1:0][31:0]  rdat, maddr, wdat, mrdata;

  logic [31:0]       mem [2][64];
  int                rdcnt [2];
  int                wrcnt [2];
  logic [31:0]       last_ra [2];
  logic [31:0]       last_wa [2];
  logic [31:0]       last_wd [2];
  int                cyc = 0;

  int                checks = 0;
  int                fails = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_access_unit #(.READ_LAT((g == 0) ? 1 : 3)) u_dut (
      .Clk(clk), .Rst_n(rst_n),
      .ReqValid(vld[g]), .ReqReady(rdy[g]),
      .ReqWrite(rw), .ReqSize(rsz), .ReqSigned(rsg),
      .ReqAddr(raddr), .ReqWData(rwd),
      .RespValid(rvld[g]), .RespData(rdat[g]), .RespErr(rerr[g]),
      .Address(maddr[g]), .writeData(wdat[g]),
      .MemRead(mrd[g]), .MemWrite(mwr[g]),
      .ReadData(mrdata[g])
    );
  end

  assign mrdata[0] = mem[0][maddr[0][7:2]];
  assign mrdata[1] = mem[1][maddr[1][7:2]];

  // Memory model and activity counters
  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (mrd[i]) begin
        rdcnt[i] = rdcnt[i] + 1;
        last_ra[i] = maddr[i];
      end
      if (mwr[i]) begin
        wrcnt[i] = wrcnt[i] + 1;
        last_wa[i] = maddr[i];
        last_wd[i] = wdat[i];
        mem[i][maddr[i][7:2]] = wdat[i];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_resp(input int i);
    exp_t e;
    logic have;
    have = 1'b0;
    if (i == 0) begin
      if (q0.size() > 0) begin have = 1'b1; e = q0.pop_front(); end
    end else begin
      if (q1.size() > 0) begin have = 1'b1; e = q1.pop_front(); end
    end
    if (!have) begin
      checks++;
      fails++;
      $display("FAIL unexpected_resp[%0d] actual data=%h err=%b required no response", i, rdat[i], rerr[i]);
    end else begin
      chk($sformatf("resp_data[%0d]", i), rdat[i], e.data);
      chk($sformatf("resp_err[%0d]", i), 32'(rerr[i]), 32'(e.err));
      chk($sformatf("resp_latency[%0d]", i), 32'(cyc - e.acc + 1), 32'(e.lat));
    end
  endtask

  // Monitor: invariants every cycle, responses popped against the scoreboard
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ((mrd[i] && mwr[i]) || (maddr[i][1:0] != 2'b00) ||
          (rdy[i] && (mrd[i] || mwr[i] || rvld[i]))) begin
        fails++;
        $display("FAIL invariant[%0d] actual rd=%b wr=%b addr=%h rdy=%b rv=%b required exclusive/aligned/not-ready",
                 i, mrd[i], mwr[i], maddr[i], rdy[i], rvld[i]);
      end
      if (rvld[i]) check_resp(i);
    end
  end

  task automatic send(input int i, input logic w, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] ed, input logic ee, input int el, output int acc);
    exp_t e;
    logic ok;
    ok = 1'b0;
    acc = -1;
    @(negedge clk);
    rw = w; rsz = sz; rsg = sg; raddr = a; rwd = wd;
    vld[i] = 1'b1;
    for (int t = 0; t < 100 && !ok; t++) begin
      if (rdy[i]) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout[%0d] actual ready=0 required ready=1 within 100 cycles", i);
      vld[i] = 1'b0;
      return;
    end
    acc = cyc + 1;
    e.data = ed; e.err = ee; e.lat = el; e.acc = acc;
    if (i == 0) q0.push_back(e); else q1.push_back(e);
    @(negedge clk);
    vld[i] = 1'b0;
    raddr = $urandom; rwd = $urandom; rsz = 2'($urandom); rw = 1'($urandom); rsg = 1'($urandom);
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && (q0.size() + q1.size()) != 0; t++) @(negedge clk);
    chk("drain_pending", 32'(q0.size() + q1.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int acc, acc2, r0, w0;
    for (int i = 0; i < 2; i++) begin
      rdcnt[i] = 0; wrcnt[i] = 0;
      last_ra[i] = '0; last_wa[i] = '0; last_wd[i] = '0;
      for (int j = 0; j < 64; j++) mem[i][j] = '0;
    end
    mem[0][4]  = 32'h1122_3344;
    mem[0][8]  = 32'h80FF_7F01;
    mem[0][12] = 32'hAABB_CCDD;
    mem[1][24] = 32'h0BAD_F00D;

    // Reset values
    #2;
    for (int i = 0; i < 2; i++) begin
      chk("rst_outputs", {rdy[i], rvld[i], rerr[i], mrd[i], mwr[i]}, 32'd0);
      chk("rst_data", rdat[i] | maddr[i] | wdat[i], 32'd0);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    chk("ready_before_edge", 32'(rdy[0]), 32'd0);
    @(negedge clk);
    chk("ready_after_edge", 32'(rdy), 32'd3);

    // READ_LAT=1 loads
    r0 = rdcnt[0];
    send(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h1122_3344, 1'b0, 2, acc);
    send(0, 1'b0, 2'b00, 1'b1, 32'h23, 32'h0, 32'hFFFF_FF80, 1'b0, 2, acc);
    send(0, 1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 32'h0000_80FF, 1'b0, 2, acc);
    send(0, 1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 32'h0000_007F, 1'b0, 2, acc);
    send(0, 1'b0, 2'b00, 1'b0, 32'h23, 32'h0, 32'h0000_0080, 1'b0, 2, acc);
    send(0, 1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 32'hFFFF_80FF, 1'b0, 2, acc);
    send(0, 1'b0, 2'b01, 1'b1, 32'h20, 32'h0, 32'h0000_7F01, 1'b0, 2, acc);
    drain();
    chk("load_read_cycles", 32'(rdcnt[0] - r0), 32'd7);

    // Sub-word stores (read-modify-write)
    r0 = rdcnt[0]; w0 = wrcnt[0];
    send(0, 1'b1, 2'b01, 1'b0, 32'h32, 32'hFFFF_1234, 32'h0, 1'b0, 3, acc);
    drain();
    chk("half_store_reads", 32'(rdcnt[0] - r0), 32'd1);
    chk("half_store_writes", 32'(wrcnt[0] - w0), 32'd1);
    chk("half_store_addr", last_wa[0], 32'h30);
    chk("half_store_data", last_wd[0], 32'h1234_CCDD);
    send(0, 1'b1, 2'b00, 1'b0, 32'h31, 32'hFFFF_FFAB, 32'h0, 1'b0, 3, acc);
    drain();
    chk("byte_store_data", mem[0][12], 32'h1234_ABDD);

    // Error requests make no memory access
    r0 = rdcnt[0]; w0 = wrcnt[0];
    send(0, 1'b0, 2'b10, 1'b0, 32'h41, 32'h0, 32'h0, 1'b1, 1, acc);
    send(0, 1'b1, 2'b01, 1'b0, 32'h43, 32'h5555, 32'h0, 1'b1, 1, acc);
    send(0, 1'b0, 2'b11, 1'b1, 32'h40, 32'h0, 32'h0, 1'b1, 1, acc);
    drain();
    chk("err_mem_access", 32'((rdcnt[0] - r0) + (wrcnt[0] - w0)), 32'd0);

    // READ_LAT=3: word store then load back-to-back
    w0 = wrcnt[1];
    send(1, 1'b1, 2'b10, 1'b0, 32'h50, 32'hCAFE_F00D, 32'h0, 1'b0, 2, acc);
    send(1, 1'b0, 2'b10, 1'b0, 32'h50, 32'h0, 32'hCAFE_F00D, 1'b0, 4, acc2);
    drain();
    chk("accept_gap", 32'(acc2 - acc), 32'd3);
    chk("b2b_writes", 32'(wrcnt[1] - w0), 32'd1);
    chk("b2b_read_addr", last_ra[1], 32'h50);

    // Reset during the write cycle of a store
    w0 = wrcnt[1];
    send(1, 1'b1, 2'b10, 1'b0, 32'h60, 32'h1234_5678, 32'h0, 1'b0, 2, acc);
    chk("wr_before_rst", 32'(mwr[1]), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("wr_async_drop", 32'(mwr[1]), 32'd0);
    chk("addr_async_drop", maddr[1] | wdat[1], 32'd0);
    q1.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("ready_after_release", 32'(rdy[1]), 32'd0);
    @(negedge clk);
    chk("ready_next_edge", 32'(rdy[1]), 32'd1);
    chk("aborted_write", 32'(wrcnt[1] - w0), 32'd0);
    send(1, 1'b0, 2'b10, 1'b0, 32'h60, 32'h0, 32'h0BAD_F00D, 1'b0, 4, acc);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
